// File: rtl/mag_est_pipe.sv
// mag_est_pipe: 3-stage alpha-max-plus-beta-min magnitude estimator with valid/ready flow control
// and per-frame bin indexing. Define MAG_PEAK_EN to build the frame peak tracker.
module mag_est_pipe #(
  parameter int W       = 13,
  parameter int N_BINS  = 256,
  localparam int BW     = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_re,
  input  logic [W-1:0]  in_im,
  input  logic          in_mode,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_mag,
  output logic [BW-1:0] out_bin,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  peak_mag,
  output logic [BW-1:0] peak_bin,
  output logic          peak_valid
);

  localparam int M = W - 1;
  localparam logic [M-1:0]  MAG_MAX  = {M{1'b1}};
  localparam logic [W-1:0]  S_MIN    = {1'b1, {M{1'b0}}};
  localparam logic [BW-1:0] BIN_LAST = BW'(N_BINS - 1);
  localparam logic [BW-1:0] BIN_ONE  = BW'(1);

  typedef struct packed {
    logic          valid;
    logic [M-1:0]  a;
    logic [M-1:0]  b;
    logic          mode;
    logic          last;
    logic [BW-1:0] bin;
  } s1_t;

  typedef struct packed {
    logic          valid;
    logic [M-1:0]  t1;
    logic [M-1:0]  t2;
    logic [M-1:0]  mx;
    logic          mode;
    logic          last;
    logic [BW-1:0] bin;
  } s2_t;

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  mag;
    logic [BW-1:0] bin;
    logic          last;
  } s3_t;

  // Absolute value; the most negative code has no positive twin, so it saturates.
  function automatic logic [M-1:0] sat_abs(input logic [W-1:0] v);
    logic [M-1:0] neg;
    neg = (~v[M-1:0]) + {{(M-1){1'b0}}, 1'b1};
    if (v == S_MIN) begin
      sat_abs = MAG_MAX;
    end else if (v[W-1]) begin
      sat_abs = neg;
    end else begin
      sat_abs = v[M-1:0];
    end
  endfunction

  logic          adv_s;
  logic          accept_s;
  logic          eff_last_s;
  logic [BW-1:0] bin_q, bin_d;
  s1_t           s1_q, s1_d;
  s2_t           s2_q, s2_d;
  s3_t           s3_q, s3_d;
  logic [M-1:0]  mx_s, mn_s, clip_s;
  logic [W:0]    sum_s, res_s;

  // Global advance and frame bin counter.
  always_comb begin
    adv_s      = out_ready | ~s3_q.valid;
    accept_s   = in_valid & adv_s;
    eff_last_s = in_last | (bin_q == BIN_LAST);
    if (accept_s) begin
      if (eff_last_s) begin
        bin_d = {BW{1'b0}};
      end else begin
        bin_d = bin_q + BIN_ONE;
      end
    end else begin
      bin_d = bin_q;
    end
  end

  // Stage 1: saturating absolute values plus sideband.
  always_comb begin
    s1_d = s1_q;
    if (adv_s) begin
      s1_d.valid = in_valid;
      s1_d.a     = sat_abs(in_re);
      s1_d.b     = sat_abs(in_im);
      s1_d.mode  = in_mode;
      s1_d.last  = eff_last_s;
      s1_d.bin   = bin_q;
    end else begin
      s1_d = s1_q;
    end
  end

  // Stage 2: max/min sort and mode-dependent scaled terms.
  always_comb begin
    mx_s = (s1_q.b > s1_q.a) ? s1_q.b : s1_q.a;
    mn_s = (s1_q.b > s1_q.a) ? s1_q.a : s1_q.b;
    s2_d = s2_q;
    if (adv_s) begin
      s2_d.valid = s1_q.valid;
      s2_d.mx    = mx_s;
      s2_d.mode  = s1_q.mode;
      s2_d.last  = s1_q.last;
      s2_d.bin   = s1_q.bin;
      if (s1_q.mode) begin
        s2_d.t1 = mx_s;
        s2_d.t2 = mn_s >> 2'd2;
      end else begin
        s2_d.t1 = mx_s - (mx_s >> 2'd3);
        s2_d.t2 = mn_s >> 1'd1;
      end
    end else begin
      s2_d = s2_q;
    end
  end

  // Stage 3: sum, mode-0 floor at max, clip so the result stays non-negative.
  always_comb begin
    sum_s = {2'b00, s2_q.t1} + {2'b00, s2_q.t2};
    if (!s2_q.mode && (sum_s < {2'b00, s2_q.mx})) begin
      res_s = {2'b00, s2_q.mx};
    end else begin
      res_s = sum_s;
    end
    if (res_s > {2'b00, MAG_MAX}) begin
      clip_s = MAG_MAX;
    end else begin
      clip_s = res_s[M-1:0];
    end
    s3_d = s3_q;
    if (adv_s) begin
      s3_d.valid = s2_q.valid;
      s3_d.mag   = {1'b0, clip_s};
      s3_d.bin   = s2_q.bin;
      s3_d.last  = s2_q.last;
    end else begin
      s3_d = s3_q;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= {BW{1'b0}};
      s1_q  <= {$bits(s1_t){1'b0}};
      s2_q  <= {$bits(s2_t){1'b0}};
      s3_q  <= {$bits(s3_t){1'b0}};
    end else begin
      bin_q <= bin_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
    end
  end

  assign in_ready  = adv_s;
  assign out_valid = s3_q.valid;
  assign out_mag   = s3_q.mag;
  assign out_bin   = s3_q.bin;
  assign out_last  = s3_q.last;

`ifdef MAG_PEAK_EN
  logic [W-1:0]  run_max_q, run_max_d, peak_mag_q, peak_mag_d, fin_max_s;
  logic [BW-1:0] run_bin_q, run_bin_d, peak_bin_q, peak_bin_d, fin_bin_s;
  logic          peak_valid_q, peak_valid_d;
  logic          xfer_s, take_s;

  // Running frame maximum; strict compare keeps the earliest bin on ties.
  always_comb begin
    xfer_s       = s3_q.valid & out_ready;
    take_s       = s3_q.mag > run_max_q;
    fin_max_s    = take_s ? s3_q.mag : run_max_q;
    fin_bin_s    = take_s ? s3_q.bin : run_bin_q;
    run_max_d    = run_max_q;
    run_bin_d    = run_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_bin_d   = peak_bin_q;
    peak_valid_d = 1'b0;
    if (xfer_s) begin
      if (s3_q.last) begin
        peak_mag_d   = fin_max_s;
        peak_bin_d   = fin_bin_s;
        peak_valid_d = 1'b1;
        run_max_d    = {W{1'b0}};
        run_bin_d    = {BW{1'b0}};
      end else begin
        run_max_d = fin_max_s;
        run_bin_d = fin_bin_s;
      end
    end else begin
      peak_valid_d = 1'b0;
    end
  end

  // Peak tracker registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_max_q    <= {W{1'b0}};
      run_bin_q    <= {BW{1'b0}};
      peak_mag_q   <= {W{1'b0}};
      peak_bin_q   <= {BW{1'b0}};
      peak_valid_q <= 1'b0;
    end else begin
      run_max_q    <= run_max_d;
      run_bin_q    <= run_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_bin_q   <= peak_bin_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  assign peak_mag   = peak_mag_q;
  assign peak_bin   = peak_bin_q;
  assign peak_valid = peak_valid_q;
`else
  assign peak_mag   = {W{1'b0}};
  assign peak_bin   = {BW{1'b0}};
  assign peak_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mag_est_pipe.sv
// tb_mag_est_pipe: directed vectors with hand-computed magnitudes, scoreboard queue and
// decoupled output monitor. Built with N_BINS=8 so frame wrap is exercised.
`timescale 1ns/1ps
module tb_mag_est_pipe;
  localparam int W  = 13;
  localparam int NB = 8;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_re, in_im;
  logic          in_mode, in_last, in_valid, in_ready;
  logic [W-1:0]  out_mag;
  logic [BW-1:0] out_bin;
  logic          out_last, out_valid, out_ready;
  logic [W-1:0]  peak_mag;
  logic [BW-1:0] peak_bin;
  logic          peak_valid;

  mag_est_pipe #(.W(W), .N_BINS(NB)) dut (
    .clk(clk), .rst(rst),
    .in_re(in_re), .in_im(in_im), .in_mode(in_mode), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_mag(out_mag), .out_bin(out_bin), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .peak_mag(peak_mag), .peak_bin(peak_bin), .peak_valid(peak_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int mag; int bin; bit last; bit lat; int acc_cyc; } exp_t;
  typedef struct { int mag; int bin; } pk_t;
  exp_t exp_q[$];
  pk_t  pk_q[$];
  exp_t e;
  pk_t  p;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cur_mag, cur_bin;
  bit   cur_last, cur_lat;
  int   rm = 0, rb = 0, last_xfer_cyc = -10;
  bit   stalled = 1'b0;
  int   held_mag, held_bin, held_last;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard push on every accepted sample; reset discards in-flight expectations.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      pk_q.delete();
      rm = 0;
      rb = 0;
    end else if (in_valid && in_ready) begin
      exp_q.push_back('{cur_mag, cur_bin, cur_last, cur_lat, cyc});
    end
    cyc = cyc + 1;
  end

  // Output monitor: stall stability, ordered compare, frame peak reference.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        if (stalled) begin
          chk("stall_mag", out_mag, held_mag);
          chk("stall_bin", out_bin, held_bin);
          chk("stall_last", out_last, held_last);
        end
        stalled   = 1'b1;
        held_mag  = out_mag;
        held_bin  = out_bin;
        held_last = out_last;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out mag=%0d bin=%0d required=none", out_mag, out_bin);
        end else begin
          e = exp_q.pop_front();
          chk("out_mag", out_mag, e.mag);
          chk("out_bin", out_bin, e.bin);
          chk("out_last", out_last, e.last);
          if (e.lat) chk("latency", cyc - e.acc_cyc, 3);
          if (e.mag > rm) begin
            rm = e.mag;
            rb = e.bin;
          end
          if (e.last) begin
            pk_q.push_back('{rm, rb});
            rm = 0;
            rb = 0;
            last_xfer_cyc = cyc;
          end
        end
`ifndef MAG_PEAK_EN
        chk("peak_off", int'(peak_valid) + int'(peak_mag) + int'(peak_bin), 0);
`endif
      end
`ifdef MAG_PEAK_EN
      if (peak_valid) begin
        if (pk_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_peak mag=%0d bin=%0d required=none", peak_mag, peak_bin);
        end else begin
          p = pk_q.pop_front();
          chk("peak_mag", peak_mag, p.mag);
          chk("peak_bin", peak_bin, p.bin);
          chk("peak_delay", cyc - last_xfer_cyc, 1);
        end
      end
`endif
    end
  end

  task automatic send(input int re, input int im, input bit mode, input bit last,
                      input int mag, input int bin, input bit elast, input bit lat);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_re    = re[W-1:0];
    in_im    = im[W-1:0];
    in_mode  = mode;
    in_last  = last;
    in_valid = 1'b1;
    cur_mag  = mag;
    cur_bin  = bin;
    cur_last = elast;
    cur_lat  = lat;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_re = '0; in_im = '0; in_mode = 1'b0; in_last = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mag", out_mag, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_peak", int'(peak_valid) + int'(peak_mag) + int'(peak_bin), 0);

    // Mode 0/1 vectors back-to-back; bin 7 forces last without in_last.
    send(3, 4, 0, 0, 5, 0, 0, 1);
    send(1000, -1000, 0, 0, 1375, 1, 0, 1);
    send(-4096, 0, 0, 0, 4095, 2, 0, 1);
    send(3, 4, 1, 0, 4, 3, 0, 1);
    send(1000, 1000, 1, 0, 1250, 4, 0, 1);
    send(4095, 4095, 1, 0, 4095, 5, 0, 1);
    send(3, 4, 0, 0, 5, 6, 0, 1);
    send(3, 4, 1, 0, 4, 7, 1, 1);
    drain();

    // Eight samples with downstream stalled for three cycles.
    fork
      for (int i = 0; i < 8; i++) send(10 * (i + 1), 0, 1, (i == 7), 10 * (i + 1), i, (i == 7), 0);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Short frame of 5, then 10 without in_last (wrap at 7), then close the frame.
    for (int i = 0; i < 5; i++) send(100 + i, 0, 1, (i == 4), 100 + i, i, (i == 4), 1);
    for (int i = 0; i < 10; i++) send(110 + i, 0, 1, 0, 110 + i, i % NB, ((i % NB) == 7), 1);
    send(120, 0, 1, 1, 120, 2, 1, 1);
    drain();

    // Peak frame {5,20,7,20,3}.
    send(3, 4, 0, 0, 5, 0, 0, 1);
    send(16, 12, 0, 0, 20, 1, 0, 1);
    send(7, 0, 1, 0, 7, 2, 0, 1);
    send(0, -20, 1, 0, 20, 3, 0, 1);
    send(3, 0, 0, 1, 3, 4, 1, 1);
    drain();
`ifdef MAG_PEAK_EN
    chk("peak_frame_mag", peak_mag, 20);
    chk("peak_frame_bin", peak_bin, 1);
`else
    chk("peak_frame_off", int'(peak_mag) + int'(peak_bin), 0);
`endif

    // Mid-frame reset with two samples in flight.
    send(20, 0, 1, 0, 20, 0, 0, 1);
    drain();
    send(30, 0, 1, 0, 30, 1, 0, 1);
    send(40, 0, 1, 0, 40, 2, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_peak", int'(peak_valid) + int'(peak_mag) + int'(peak_bin), 0);
    send(3, 4, 0, 1, 5, 0, 1, 1);
    drain();
`ifdef MAG_PEAK_EN
    chk("peak_after_rst_mag", peak_mag, 5);
    chk("peak_after_rst_bin", peak_bin, 0);
    chk("peak_queue_empty", pk_q.size(), 0);
`endif
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
